// File: rtl/pcpu_pkg.sv
// Shared pipeline-control definitions: FSM state codes, forwarding selects,
// writeback/next-PC select encodings and the forwarding priority helper.
package pcpu_pkg;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic [1:0] {
        WD_ALU = 2'b00,
        WD_MEM = 2'b01,
        WD_PC4 = 2'b10
    } wd_sel_e;

    typedef enum logic [1:0] {
        NPC_PC4    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JALR   = 2'b11
    } npc_op_e;

    // The younger producer (MEM) holds the newer value, so it wins over WB.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic       mem_regwrite,
        input logic [4:0] wb_rd,
        input logic       wb_regwrite
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (mem_regwrite && mem_rd != 5'd0 && mem_rd == rs)
            sel = FWD_MEM;
        else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == rs)
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational hazard detection: load-use in ID against a load in EX, and
// ALU operand forwarding selects for the EX stage.
module fwd_unit
    import pcpu_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic       load_use,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    always_comb begin
        load_use = ex_memread && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && id_rs1 == ex_rd) ||
                    (id_use_rs2 && id_rs2 == ex_rd));
        fwd_a = fwd_sel(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        fwd_b = fwd_sel(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: memory-wait freeze, redirect flush, load-use
// bubble, forwarding selects, saturating event counters and a sticky timeout.
module pipe_ctrl
    import pcpu_pkg::*;
#(
    parameter int WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic        ex_redirect,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regwrite,
    input  logic        mem_req,
    input  logic        dmem_ack,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_flush,
    output logic        dmem_req,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [31:0] stall_cnt,
    output logic [31:0] redir_cnt,
    output logic        dmem_err,
    output logic        state_dbg
);

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    // Memory handshake: dmem_req is held high from the cycle the access is
    // presented until the cycle dmem_ack is seen high; the access completes on
    // that ack cycle and nothing is outstanding afterwards.
    logic [0:0] state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_inc;
    logic       load_use;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;
    logic       mem_stall;
    logic       redirect_take;

    fwd_unit u_fwd (
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_memread   (ex_memread),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .load_use     (load_use),
        .fwd_a        (fwd_a_raw),
        .fwd_b        (fwd_b_raw)
    );

    assign state_dbg = state[0];
    assign wait_inc  = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    assign mem_stall = ((state == ST_RUN) && mem_req && !dmem_ack) ||
                       ((state == ST_MEM_WAIT) && !dmem_ack);

    always_comb begin
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        memwb_flush   = 1'b0;
        dmem_req      = mem_req || (state == ST_MEM_WAIT);
        fwd_a         = fwd_a_raw;
        fwd_b         = fwd_b_raw;
        redirect_take = 1'b0;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
            dmem_req    = 1'b0;
            fwd_a       = FWD_NONE;
            fwd_b       = FWD_NONE;
        end else if (mem_stall) begin
            // Freeze everything upstream of MEM; WB drains a bubble.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            redirect_take = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            wait_cnt  <= 8'd0;
            dmem_err  <= 1'b0;
            stall_cnt <= 32'd0;
            redir_cnt <= 32'd0;
        end else begin
            if (!pc_en && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (redirect_take && redir_cnt != 32'hFFFF_FFFF)
                redir_cnt <= redir_cnt + 32'd1;

            case (state)
                ST_RUN: begin
                    wait_cnt <= 8'd0;
                    if (mem_req && !dmem_ack)
                        state <= ST_MEM_WAIT;
                end
                default: begin
                    if (dmem_ack) begin
                        state    <= ST_RUN;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (wait_inc == WAIT_LIM)
                            dmem_err <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized checks of pipe_ctrl against a transaction-level
// model: an outstanding-access flag, a wait tally and event counters.
module tb_pipe_ctrl;

    localparam int WAIT_MAX = 4;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_use_rs1, id_use_rs2, ex_regwrite, ex_memread, ex_redirect;
    logic        mem_regwrite, wb_regwrite, mem_req, dmem_ack;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, memwb_flush, dmem_req, dmem_err, state_dbg;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt, redir_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_busy;
    int          m_wait;
    bit          m_err;
    bit [31:0]   m_stall;
    bit [31:0]   m_redir;

    pipe_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .mem_req(mem_req), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .dmem_req(dmem_req), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .redir_cnt(redir_cnt),
        .dmem_err(dmem_err), .state_dbg(state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", name, got, exp);
            $error("%s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Compare every output against the model for the current inputs, then
    // advance the model as the coming clock edge will.
    task automatic check_all(input string tag);
        bit pend, frz, lu, redir_now;
        bit [4:0] e_en;   // pc, ifid, idex, exmem, memwb
        bit [2:0] e_fl;   // ifid, idex, memwb
        bit       e_req;
        bit [1:0] e_fa, e_fb;
        pend = m_busy || mem_req;
        frz  = pend && !dmem_ack;
        lu   = ex_memread && ex_rd != 0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        redir_now = 0;
        e_en = 5'b11111; e_fl = 3'b000; e_req = pend;
        e_fa = model_fwd(ex_rs1); e_fb = model_fwd(ex_rs2);
        if (rst) begin
            e_fl = 3'b111; e_req = 0; e_fa = 0; e_fb = 0;
        end else if (frz) begin
            e_en = 5'b00001; e_fl = 3'b001;
        end else if (ex_redirect) begin
            e_fl = 3'b110; redir_now = 1;
        end else if (lu) begin
            e_en = 5'b00111; e_fl = 3'b010;
        end
        chk({tag, ".en"}, {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {27'd0, e_en});
        chk({tag, ".flush"}, {29'd0, ifid_flush, idex_flush, memwb_flush}, {29'd0, e_fl});
        chk({tag, ".dmem_req"}, {31'd0, dmem_req}, {31'd0, e_req});
        chk({tag, ".fwd"}, {28'd0, fwd_a, fwd_b}, {28'd0, e_fa, e_fb});
        chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
        chk({tag, ".redir_cnt"}, redir_cnt, m_redir);
        chk({tag, ".dmem_err"}, {31'd0, dmem_err}, {31'd0, m_err});
        chk({tag, ".state"}, {31'd0, state_dbg}, {31'd0, m_busy});

        if (rst) begin
            m_busy = 0; m_wait = 0; m_err = 0; m_stall = 0; m_redir = 0;
        end else begin
            if (e_en[4] == 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (redir_now && m_redir != 32'hFFFF_FFFF) m_redir++;
            if (m_busy && !dmem_ack) begin
                if (m_wait < 255) m_wait++;
                if (m_wait == WAIT_MAX) m_err = 1;
            end else begin
                m_wait = 0;
            end
            m_busy = frz;
        end
    endtask

    // Driver tasks
    task automatic step(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
        ex_redirect = 0; mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
        mem_req = 0; dmem_ack = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step("reset");
        rst = 0;
    endtask

    task automatic random_inputs();
        id_rs1 = 5'($urandom_range(0, 3));   id_rs2 = 5'($urandom_range(0, 3));
        id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
        ex_rs1 = 5'($urandom_range(0, 3));   ex_rs2 = 5'($urandom_range(0, 3));
        ex_rd  = 5'($urandom_range(0, 3));   ex_regwrite = 1'($urandom_range(0, 1));
        ex_memread  = ($urandom_range(0, 3) == 0);
        ex_redirect = ($urandom_range(0, 7) == 0);
        mem_rd = 5'($urandom_range(0, 3));   mem_regwrite = 1'($urandom_range(0, 1));
        wb_rd  = 5'($urandom_range(0, 3));   wb_regwrite = 1'($urandom_range(0, 1));
        mem_req  = ($urandom_range(0, 3) == 0);
        dmem_ack = ($urandom_range(0, 2) != 0);
        rst      = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        m_busy = 0; m_wait = 0; m_err = 0; m_stall = 0; m_redir = 0;
        @(posedge clk);
        #1;

        // Reset overrides a pending request and forwarding matches
        mem_req = 1; ex_rs1 = 3; mem_rd = 3; mem_regwrite = 1;
        #1;
        chk("rst_pc_en", {31'd0, pc_en}, 32'd1);
        chk("rst_flushes", {29'd0, ifid_flush, idex_flush, memwb_flush}, 32'd7);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
        step("rst_hold");
        do_reset();
        #1;
        chk("post_rst_stall", stall_cnt, 32'd0);
        chk("post_rst_redir", redir_cnt, 32'd0);
        chk("post_rst_err", {31'd0, dmem_err}, 32'd0);

        // lw x5 in EX, add reading x5 in ID
        ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        #1;
        chk("lu_pc_en", {31'd0, pc_en}, 32'd0);
        chk("lu_ifid_en", {31'd0, ifid_en}, 32'd0);
        chk("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
        step("lu");
        ex_memread = 0; ex_rd = 0;
        #1;
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        chk("lu_single_bubble", {31'd0, pc_en}, 32'd1);
        step("lu_after");

        // Forwarding priority
        idle_inputs();
        ex_rs1 = 3; mem_rd = 3; mem_regwrite = 1; wb_rd = 3; wb_regwrite = 1;
        #1;
        chk("fwd_mem", {30'd0, fwd_a}, 32'd2);
        step("fwd_mem");
        mem_rd = 0;
        #1;
        chk("fwd_wb", {30'd0, fwd_a}, 32'd1);
        step("fwd_wb");
        wb_rd = 0;
        #1;
        chk("fwd_x0", {30'd0, fwd_a}, 32'd0);
        ex_rs2 = 7; wb_rd = 7;
        #1;
        chk("fwd_b_wb", {30'd0, fwd_b}, 32'd1);
        step("fwd_x0");

        // Memory access with three cycles of wait
        do_reset();
        mem_req = 1; dmem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_req", {31'd0, dmem_req}, 32'd1);
            chk("mw_frozen", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'd1);
            chk("mw_memwb_flush", {31'd0, memwb_flush}, 32'd1);
            step("mw_wait");
        end
        dmem_ack = 1;
        #1;
        chk("mw_ack_req", {31'd0, dmem_req}, 32'd1);
        chk("mw_ack_run", {31'd0, pc_en}, 32'd1);
        step("mw_ack");
        mem_req = 0; dmem_ack = 0;
        #1;
        chk("mw_state_run", {31'd0, state_dbg}, 32'd0);
        chk("mw_stall_cnt", stall_cnt, 32'd3);
        step("mw_done");

        // Redirect with a simultaneous load-use
        do_reset();
        ex_redirect = 1; ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        #1;
        chk("rd_flushes", {30'd0, ifid_flush, idex_flush}, 32'd3);
        chk("rd_pc_en", {31'd0, pc_en}, 32'd1);
        step("redirect");
        idle_inputs();
        #1;
        chk("rd_redir_cnt", redir_cnt, 32'd1);
        chk("rd_stall_cnt", stall_cnt, 32'd0);
        step("rd_after");

        // Timeout and reset during a wait
        do_reset();
        mem_req = 1; dmem_ack = 0;
        step("to_enter");
        mem_req = 0;
        for (int i = 0; i < 3; i++) step("to_wait");
        #1;
        chk("to_err_early", {31'd0, dmem_err}, 32'd0);
        step("to_wait4");
        #1;
        chk("to_err_set", {31'd0, dmem_err}, 32'd1);
        step("to_sticky");
        #1;
        chk("to_err_sticky", {31'd0, dmem_err}, 32'd1);
        rst = 1;
        #1;
        chk("to_rst_req", {31'd0, dmem_req}, 32'd0);
        step("to_rst");
        rst = 0;
        #1;
        chk("to_rst_state", {31'd0, state_dbg}, 32'd0);
        chk("to_rst_err", {31'd0, dmem_err}, 32'd0);
        chk("to_rst_stall", stall_cnt, 32'd0);
        chk("to_rst_redir", redir_cnt, 32'd0);
        step("to_after");

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            random_inputs();
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter: WAIT_MAX, 255, max MEM_WAIT cycles before dmem_err sets.
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: id_rs1/id_rs2  in  5 each  ID-stage source registers.
REQ-005 SHALL have ports: id_use_rs1/id_use_rs2  in  1 each  ID instruction reads that source.
REQ-006 SHALL have ports: ex_rs1/ex_rs2  in  5 each  EX-stage source registers.
REQ-007 SHALL have ports: ex_rd  in  5; ex_regwrite  in  1; ex_memread  in  1 (EX holds a load).
REQ-008 SHALL have port: ex_redirect  in  1  taken branch, jal or jalr resolved in EX.
REQ-009 SHALL have ports: mem_rd  in  5; mem_regwrite  in  1; wb_rd  in  5; wb_regwrite  in  1.
REQ-010 SHALL have ports: mem_req  in  1 (MEM holds load/store); dmem_ack  in  1 (access completes this cycle).
REQ-011 SHALL have ports: pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables.
REQ-012 SHALL have ports: ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble.
REQ-013 SHALL have ports: dmem_req  out  1; fwd_a/fwd_b  out  2 each  ALU operand select.
REQ-014 SHALL have ports: stall_cnt, redir_cnt  out  32 each; dmem_err  out  1 sticky timeout flag.

Function
REQ-015 SHALL implement FSM RUN/MEM_WAIT; RUN->MEM_WAIT when mem_req & !dmem_ack; MEM_WAIT->RUN on dmem_ack.
REQ-016 SHALL drive dmem_req = mem_req in RUN, 1 in MEM_WAIT.
REQ-017 SHALL, whenever the memory is stalled (RUN with mem_req & !dmem_ack, or MEM_WAIT & !dmem_ack), drive pc_en=ifid_en=idex_en=exmem_en=0, memwb_en=1, memwb_flush=1; freeze overrides redirect and load-use.
REQ-018 SHALL detect load-use as ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-019 SHALL, when not frozen and ex_redirect=1, drive all enables 1, ifid_flush=1, idex_flush=1; redirect wins over load-use.
REQ-020 SHALL, when not frozen, no redirect, load-use true, drive pc_en=ifid_en=0, idex_flush=1, other enables 1; exactly one bubble per hazard.
REQ-021 SHALL otherwise drive all enables 1, all flushes 0.
REQ-022 SHALL compute fwd_a: 2'b10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1; else 2'b01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1; else 2'b00; fwd_b identically on ex_rs2; MEM beats WB.
REQ-023 SHALL increment stall_cnt each cycle pc_en=0, redir_cnt each cycle REQ-019 applies; both saturate at 32'hFFFF_FFFF.
REQ-024 SHALL count consecutive MEM_WAIT cycles (8-bit) and set dmem_err on the cycle the count reaches WAIT_MAX without ack; dmem_err cleared only by rst.
REQ-025 SHALL keep all control outputs combinational from state and inputs (zero latency); counters, FSM, dmem_err registered.

Reset
REQ-026 SHALL, on rising clk with rst=1, set state=RUN, stall_cnt=0, redir_cnt=0, wait counter=0, dmem_err=0.
REQ-027 SHALL, while rst=1, drive all enables 1, all flushes 1, dmem_req=0, fwd_a=fwd_b=2'b00, aborting any MEM_WAIT.

Structure
REQ-028 SHALL take state encoding (RUN=0, MEM_WAIT=1), FWD_NONE/FWD_WB/FWD_MEM constants and WDSel/NPCOp encodings from shared package pcpu_pkg.
REQ-029 SHALL place REQ-018 and REQ-022 logic in one combinational sub-module fwd_unit.

Verification
REQ-030 SHALL test: lw x5 in EX (ex_memread=1, ex_rd=5), ID add using rs1=5 -> one cycle pc_en=0, ifid_en=0, idex_flush=1, stall_cnt=1.
REQ-031 SHALL test: mem_rd=3 mem_regwrite=1, wb_rd=3 wb_regwrite=1, ex_rs1=3 -> fwd_a=2'b10; mem_rd=0 variant -> fwd_a=2'b01; rd=x0 both -> 2'b00.
REQ-032 SHALL test: mem_req=1, dmem_ack low 3 cycles then high -> dmem_req=1 4 cycles, pipeline frozen 3 cycles, state back to RUN, stall_cnt=3.
REQ-033 SHALL test: ex_redirect=1 with simultaneous load-use -> ifid_flush=idex_flush=1, pc_en=1, redir_cnt=1, stall_cnt unchanged.
REQ-034 SHALL test: WAIT_MAX=4, dmem_ack held low -> dmem_err=1 after 4 MEM_WAIT cycles; assert rst mid-wait -> state RUN, dmem_err=0, counters 0 next cycle.
